// File: rtl/pattern_tx.sv
// Framed serial transmitter: each accepted word goes out as sync pattern, payload (MSB first),
// then a run of forced-zero gap cycles, all on a registered serial line.
module pattern_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter logic [3:0]  SYNC_PAT   = 4'b1010,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              x,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned CNT_W = ($clog2(DATA_W) > 4) ? $clog2(DATA_W) : 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSync = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StGap  = 2'd3;

  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SyncLast = CNT_W'(3);
  localparam logic [CNT_W-1:0] DataLast = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam bit               NoGap    = (GAP_CYCLES == 0);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              x_q, x_d;
  logic [7:0]        frame_cnt_q;
  logic [1:0]        sync_idx;

  assign din_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign x          = x_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = ((state_q == StGap) && (cnt_q == GapLast)) ||
                      (NoGap && (state_q == StData) && (cnt_q == DataLast));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (din_valid) begin
          state_d = StSync;
          cnt_d   = '0;
          shift_d = din;
        end
      end
      StSync: begin
        if (cnt_q == SyncLast) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StData: begin
        if (cnt_q == DataLast) begin
          state_d = NoGap ? StIdle : StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // x is registered, so it is computed from the state the next cycle will be in.
    if (state_d == StData) begin
      shift_d = {shift_q[DATA_W-2:0], 1'b0};
    end

    sync_idx = 2'd3 - cnt_d[1:0];
    case (state_d)
      StSync:  x_d = SYNC_PAT[sync_idx];
      StData:  x_d = shift_q[DATA_W-1];
      default: x_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      x_q         <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      x_q     <= x_d;
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Parameters
REQ-001 DATA_W, 8, payload bits per frame.
REQ-002 SYNC_PAT, 4'b1010, sync pattern sent ahead of every payload, MSB first.
REQ-003 GAP_CYCLES, 2, forced-zero cycles after payload; legal range 0..15.

Interface
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-006 din  input  DATA_W  payload word, sampled on handshake.
REQ-007 din_valid  input  1  payload offered.
REQ-008 din_ready  output  1  block accepts payload this cycle; high only in IDLE.
REQ-009 x  output  1  registered serial line, same line the team's 1010 Mealy detector samples.
REQ-010 busy  output  1  high in SYNC, DATA, GAP.
REQ-011 frame_done  output  1  one-cycle pulse in final bit-cycle of a frame.
REQ-012 frame_cnt  output  8  completed-frame count, wraps 255->0.

Function
REQ-013 States SHALL be IDLE, SYNC, DATA, GAP; 2-bit encoding; unused codes go to IDLE.
REQ-014 Handshake SHALL occur on a rising edge with din_valid=1 and din_ready=1; din is latched into a shift register on that edge.
REQ-015 din_ready SHALL be combinational (state==IDLE); din_valid outside IDLE SHALL be ignored, no latching, no queuing.
REQ-016 With handshake at edge N, x SHALL carry SYNC_PAT[3..0] in cycles N+1..N+4, din[DATA_W-1..0] in cycles N+5..N+4+DATA_W, then 0 for GAP_CYCLES cycles.
REQ-017 x SHALL be 0 in IDLE and GAP.
REQ-018 frame_done SHALL pulse in the last GAP cycle; if GAP_CYCLES=0, in the last DATA cycle.
REQ-019 frame_cnt SHALL increment on the edge ending the frame_done cycle, modulo 256.
REQ-020 State SHALL return to IDLE on the edge after the frame_done cycle; minimum spacing between handshakes is 4+DATA_W+GAP_CYCLES+1 cycles.
REQ-021 Bit counter SHALL be 4 bits wide minimum and reload on each state entry; no counter overflow for legal parameters.
REQ-022 Payload containing 1010 is transmitted unescaped; no extra detection-avoidance logic.
REQ-023 din changing after handshake SHALL NOT affect the frame in flight.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, x=0, busy=0, frame_done=0, frame_cnt=0, shift register=0; din_ready=1 from the next cycle.
REQ-025 Reset mid-frame SHALL abort the frame without a frame_done pulse or count increment.
REQ-026 rst and din_valid high together SHALL give no handshake; rst has priority.

Verification
REQ-027 After reset, din=8'hA5 with valid, GAP=2 -> x = 1,0,1,0,1,0,1,0,0,1,0,1,0,0 in cycles N+1..N+14; frame_done high only in N+14; frame_cnt=1.
REQ-028 Feed the x output into the 1010 detector -> y pulses at end of sync and on each 1010 in payload (hA5: 2 sync-region hits plus payload hits), matching a golden model.
REQ-029 din_valid held high continuously, din=8'hFF then 8'h00 -> handshakes exactly 15 cycles apart (GAP=2); din_valid during busy ignored; frame_cnt=2.
REQ-030 rst asserted at cycle N+7 of a frame -> x=0 and busy=0 next cycle; no frame_done; frame_cnt=0.
REQ-031 256 back-to-back frames -> frame_cnt wraps to 0; frame_done count equals 256.
REQ-032 GAP_CYCLES=0 build, din=8'h0F -> frame_done in cycle N+12; din_ready high in cycle N+13.
